// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: RISC-V load/store funct3 codes,
// response ownership and the registered load-response record.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    typedef struct packed {
        logic       valid;
        owner_e     owner;
        logic [2:0] funct3;
        logic [1:0] off;
    } resp_t;

    // Unknown funct3 codes are rejected the same way as a misaligned address.
    function automatic logic misaligned_access(input logic [2:0] funct3, input logic [1:0] off);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Right-aligns the addressed byte/half/word of a memory word and sign- or
// zero-extends it according to the load funct3.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {off, 3'b000};
        data    = shifted;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Arbitrates the single-port data memory between the core load/store path and an
// external port, generates lane masks/data and returns aligned load data one cycle later.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_funct3,
    output logic        core_gnt,
    output logic        core_stall,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_misalign,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [3:0]  ext_be,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic [31:0] mem_addrL,
    output logic [31:0] mem_addrS,
    output logic [31:0] mem_data_wr,
    output logic        mem_wr_E,
    output logic        mem_cs_E,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_data_rd
);

    localparam int IW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    logic [SW-1:0] starve_reg, starve_next;
    resp_t         resp_reg, resp_next;

    logic          core_sel, ext_sel, misalign, core_issue, issue, issue_we;
    logic [1:0]    off;
    logic [IW-1:0] core_idx, ext_idx, idx;
    logic [3:0]    core_mask;
    logic [31:0]   core_data, aligned_rdata;
    logic          unused_addr_bits;

    assign off              = core_addr[1:0];
    assign core_idx         = core_addr[2 +: IW];
    assign ext_idx          = ext_addr[IW-1:0];
    assign unused_addr_bits = ^{core_addr[31:IW+2], ext_addr[31:IW]};
    assign misalign         = misaligned_access(core_funct3, off);

    // Core has priority until ext has been denied STARVE_MAX cycles in a row.
    assign core_sel      = core_req && (!ext_req || (starve_reg != STARVE_LIMIT));
    assign ext_sel       = ext_req && !core_sel;
    assign core_gnt      = core_sel;
    assign ext_gnt       = ext_sel;
    assign core_stall    = core_req && !core_sel;
    assign core_misalign = core_sel && misalign;
    assign core_issue    = core_sel && !misalign;
    assign issue         = core_issue || ext_sel;

    always_comb begin
        core_mask = 4'b1111;
        core_data = core_wdata;
        case (core_funct3[1:0])
            2'b00: begin
                core_mask = 4'b0001 << off;
                core_data = {4{core_wdata[7:0]}};
            end
            2'b01: begin
                core_mask = 4'b0011 << off;
                core_data = {2{core_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_cs_E    = 1'b1;
        mem_wr_E    = 1'b0;
        mem_mask    = 4'b0000;
        mem_addrL   = '0;
        mem_addrS   = '0;
        mem_data_wr = '0;
        idx         = '0;
        issue_we    = 1'b0;
        if (core_issue) begin
            idx      = core_idx;
            issue_we = core_we;
        end else if (ext_sel) begin
            idx      = ext_idx;
            issue_we = ext_we;
        end
        if (issue) begin
            mem_cs_E = 1'b0;
            mem_wr_E = issue_we;
            if (issue_we) begin
                mem_addrS   = 32'(idx);
                mem_mask    = core_issue ? core_mask : ext_be;
                mem_data_wr = core_issue ? core_data : ext_wdata;
            end else begin
                mem_addrL = 32'(idx);
            end
        end
    end

    always_comb begin
        starve_next = starve_reg;
        if (!ext_req || ext_sel) begin
            starve_next = '0;
        end else if (starve_reg != STARVE_LIMIT) begin
            starve_next = starve_reg + SW'(1);
        end
    end

    // Load context is captured at issue so the aligner sees it alongside the read word.
    always_comb begin
        resp_next = '0;
        if (issue && !issue_we) begin
            resp_next.valid  = 1'b1;
            resp_next.owner  = core_issue ? OWN_CORE : OWN_EXT;
            resp_next.funct3 = core_funct3;
            resp_next.off    = off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_reg <= '0;
            resp_reg   <= '0;
        end else begin
            starve_reg <= starve_next;
            resp_reg   <= resp_next;
        end
    end

    dmem_load_align u_load_align (
        .word   (mem_data_rd),
        .off    (resp_reg.off),
        .funct3 (resp_reg.funct3),
        .data   (aligned_rdata)
    );

    assign core_rvalid = resp_reg.valid && (resp_reg.owner == OWN_CORE);
    assign ext_rvalid  = resp_reg.valid && (resp_reg.owner == OWN_EXT);
    assign core_rdata  = core_rvalid ? aligned_rdata : '0;
    assign ext_rdata   = ext_rvalid ? mem_data_rd : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic checked
// against a byte-addressed reference memory and a simple arbitration model.
module tb_dmem_ctrl;

    localparam int DEPTH      = 256;
    localparam int STARVE_MAX = 4;
    localparam int IW         = $clog2(DEPTH);
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req, core_we, ext_req, ext_we;
    logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
    logic [2:0]  core_funct3;
    logic [3:0]  ext_be;
    logic        core_gnt, core_stall, core_rvalid, core_misalign, ext_gnt, ext_rvalid;
    logic [31:0] core_rdata, ext_rdata, mem_addrL, mem_addrS, mem_data_wr, mem_data_rd;
    logic        mem_wr_E, mem_cs_E;
    logic [3:0]  mem_mask;

    logic [31:0] mem_words [DEPTH] = '{default: 32'd0};
    logic [7:0]  ref_bytes [DEPTH*4] = '{default: 8'd0};
    int checks = 0;
    int errors = 0;

    dmem_ctrl #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata), .core_misalign(core_misalign),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_be(ext_be), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_addrL(mem_addrL), .mem_addrS(mem_addrS), .mem_data_wr(mem_data_wr),
        .mem_wr_E(mem_wr_E), .mem_cs_E(mem_cs_E), .mem_mask(mem_mask),
        .mem_data_rd(mem_data_rd)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: writes land on negedge, reads registered at posedge.
    always @(negedge clk) begin
        if (mem_cs_E === 1'b0 && mem_wr_E === 1'b1)
            for (int i = 0; i < 4; i++)
                if (mem_mask[i]) mem_words[mem_addrS[IW-1:0]][8*i +: 8] = mem_data_wr[8*i +: 8];
    end

    always @(posedge clk) begin
        if (mem_cs_E === 1'b0 && mem_wr_E === 1'b0) mem_data_rd <= mem_words[mem_addrL[IW-1:0]];
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        int base;
        int n;
        longint v;
        base = int'(a % (DEPTH*4));
        n = size_of(f3);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_bytes[base+i]) << (8*i);
        if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
        return v[31:0];
    endfunction

    function automatic void ref_store_core(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        int base;
        base = int'(a % (DEPTH*4));
        for (int i = 0; i < size_of(f3); i++) ref_bytes[base+i] = d[8*i +: 8];
    endfunction

    function automatic void ref_store_ext(input logic [31:0] ea, input logic [3:0] be, input logic [31:0] d);
        int base;
        base = int'(ea % DEPTH) * 4;
        for (int i = 0; i < 4; i++) if (be[i]) ref_bytes[base+i] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] ea);
        int base;
        base = int'(ea % DEPTH) * 4;
        return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
    endfunction

    // ---------------- drive helpers ----------------
    task automatic idle();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_funct3 = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_be = 0;
    endtask

    task automatic set_core(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        core_req = 1; core_we = we; core_addr = a; core_wdata = d; core_funct3 = f3;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #4;
        $display("reset: outputs sampled with rst_n low");
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL reset_core_rvalid got %b exp 0", core_rvalid); end
        checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ext_rvalid got %b exp 0", ext_rvalid); end
        checks++; if (core_rdata !== 32'd0) begin errors++; $display("FAIL reset_core_rdata got %h exp 0", core_rdata); end
        checks++; if (ext_rdata !== 32'd0) begin errors++; $display("FAIL reset_ext_rdata got %h exp 0", ext_rdata); end
        checks++; if (mem_cs_E !== 1'b1) begin errors++; $display("FAIL reset_cs got %b exp 1", mem_cs_E); end
        checks++; if (mem_wr_E !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", mem_wr_E); end
        checks++; if (mem_mask !== 4'd0) begin errors++; $display("FAIL reset_mask got %b exp 0000", mem_mask); end
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_store_load();
        set_core(1'b1, 32'h10, 32'hDEADBEEF, LW);
        #3;
        $display("store_load: sw 0x10 0xDEADBEEF");
        checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL sw_gnt got %b exp 1", core_gnt); end
        checks++; if (mem_cs_E !== 1'b0 || mem_wr_E !== 1'b1) begin errors++; $display("FAIL sw_cs_wr got %b%b exp 01", mem_cs_E, mem_wr_E); end
        checks++; if (mem_addrS !== 32'd4) begin errors++; $display("FAIL sw_addrS got %h exp 4", mem_addrS); end
        checks++; if (mem_mask !== 4'b1111) begin errors++; $display("FAIL sw_mask got %b exp 1111", mem_mask); end
        checks++; if (mem_data_wr !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data got %h exp deadbeef", mem_data_wr); end
        ref_store_core(32'h10, LW, 32'hDEADBEEF);
        next_cycle();
        set_core(1'b0, 32'h10, 32'd0, LW);
        #3;
        $display("store_load: lw 0x10");
        checks++; if (mem_cs_E !== 1'b0 || mem_wr_E !== 1'b0) begin errors++; $display("FAIL lw_cs_wr got %b%b exp 00", mem_cs_E, mem_wr_E); end
        checks++; if (mem_addrL !== 32'd4) begin errors++; $display("FAIL lw_addrL got %h exp 4", mem_addrL); end
        checks++; if (mem_mask !== 4'd0) begin errors++; $display("FAIL lw_mask got %b exp 0000", mem_mask); end
        next_cycle();
        idle();
        #3;
        checks++; if (core_rvalid !== 1'b1) begin errors++; $display("FAIL lw_rvalid got %b exp 1", core_rvalid); end
        checks++; if (core_rdata !== ref_load(32'h10, LW)) begin errors++; $display("FAIL lw_rdata got %h exp %h", core_rdata, ref_load(32'h10, LW)); end
        next_cycle();
    endtask

    task automatic test_sign_ext();
        logic        wes   [5];
        logic [31:0] addrs [5];
        logic [2:0]  f3s   [5];
        bit          pend;
        logic [31:0] exp_d;
        wes = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        addrs = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10};
        f3s = '{LW, LB, LBU, LH, LW};
        pend = 0;
        exp_d = 0;
        for (int i = 0; i <= 5; i++) begin
            idle();
            if (i < 5) set_core(wes[i], addrs[i], 32'h80FF7F01, f3s[i]);
            #3;
            checks++; if (core_rvalid !== pend) begin errors++; $display("FAIL ext_sign_rvalid[%0d] got %b exp %b", i, core_rvalid, pend); end
            if (pend) begin
                checks++; if (core_rdata !== exp_d) begin errors++; $display("FAIL ext_sign_rdata[%0d] got %h exp %h", i, core_rdata, exp_d); end
            end
            pend = 0;
            if (i < 5) begin
                if (wes[i]) ref_store_core(addrs[i], f3s[i], 32'h80FF7F01);
                else begin
                    pend = 1;
                    exp_d = ref_load(addrs[i], f3s[i]);
                end
                $display("sign_ext: we=%0b addr=%h f3=%0d", wes[i], addrs[i], f3s[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_sb();
        set_core(1'b1, 32'h20, 32'h11223344, LW);
        #3;
        ref_store_core(32'h20, LW, 32'h11223344);
        $display("sb: sw 0x20 0x11223344");
        next_cycle();
        set_core(1'b1, 32'h21, 32'h000000AB, LB);
        #3;
        $display("sb: sb 0x21 0xAB");
        checks++; if (mem_mask !== 4'b0010) begin errors++; $display("FAIL sb_mask got %b exp 0010", mem_mask); end
        checks++; if (mem_data_wr !== 32'hABABABAB) begin errors++; $display("FAIL sb_data got %h exp abababab", mem_data_wr); end
        checks++; if (mem_addrS !== 32'd8) begin errors++; $display("FAIL sb_addrS got %h exp 8", mem_addrS); end
        ref_store_core(32'h21, LB, 32'h000000AB);
        next_cycle();
        set_core(1'b0, 32'h20, 32'd0, LW);
        $display("sb: lw 0x20");
        next_cycle();
        idle();
        #3;
        checks++; if (core_rdata !== ref_load(32'h20, LW)) begin errors++; $display("FAIL sb_readback got %h exp %h", core_rdata, ref_load(32'h20, LW)); end
        next_cycle();
    endtask

    task automatic test_arbitration();
        int starve;
        bit exp_e, prev_e;
        starve = 0;
        prev_e = 0;
        for (int c = 0; c < 6; c++) begin
            set_core(1'b0, 32'h10, 32'd0, LW);
            ext_req = 1; ext_we = 0; ext_addr = 32'd8;
            #3;
            exp_e = (starve == STARVE_MAX);
            $display("arb: cycle %0d core_gnt=%0b ext_gnt=%0b", c, core_gnt, ext_gnt);
            checks++; if (core_gnt !== !exp_e) begin errors++; $display("FAIL arb_core_gnt[%0d] got %b exp %b", c, core_gnt, !exp_e); end
            checks++; if (ext_gnt !== exp_e) begin errors++; $display("FAIL arb_ext_gnt[%0d] got %b exp %b", c, ext_gnt, exp_e); end
            checks++; if (core_stall !== exp_e) begin errors++; $display("FAIL arb_stall[%0d] got %b exp %b", c, core_stall, exp_e); end
            checks++; if (ext_rvalid !== prev_e) begin errors++; $display("FAIL arb_ext_rvalid[%0d] got %b exp %b", c, ext_rvalid, prev_e); end
            if (prev_e) begin
                checks++; if (ext_rdata !== ref_word(32'd8)) begin errors++; $display("FAIL arb_ext_rdata got %h exp %h", ext_rdata, ref_word(32'd8)); end
            end
            starve = exp_e ? 0 : ((starve < STARVE_MAX) ? starve + 1 : starve);
            prev_e = exp_e;
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_misalign();
        idle();
        set_core(1'b0, 32'h06, 32'd0, LW);
        #3;
        $display("misalign: lw 0x06");
        checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL mis_gnt got %b exp 1", core_gnt); end
        checks++; if (core_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag got %b exp 1", core_misalign); end
        checks++; if (mem_cs_E !== 1'b1) begin errors++; $display("FAIL mis_cs got %b exp 1", mem_cs_E); end
        next_cycle();
        idle();
        #3;
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL mis_rvalid got %b exp 0", core_rvalid); end
        next_cycle();
    endtask

    task automatic test_random();
        int starve, n;
        bit pend_c, pend_e, cr, er, cwe, ewe, exp_cg, exp_eg, mis, ci, exp_wr;
        logic [2:0]  f3;
        logic [3:0]  be, exp_mask;
        logic [31:0] a, ea, cd, ed, exp_c, exp_e, exp_wd;
        starve = 0; pend_c = 0; pend_e = 0; exp_c = 0; exp_e = 0;
        for (int t = 0; t < 150; t++) begin
            cr = ($urandom_range(3) != 0);
            er = 1'($urandom_range(1));
            cwe = 1'($urandom_range(1));
            ewe = 1'($urandom_range(1));
            if ($urandom_range(9) == 0) begin
                case ($urandom_range(2))
                    0: f3 = 3'd3;
                    1: f3 = 3'd6;
                    default: f3 = 3'd7;
                endcase
            end else if (cwe) begin
                f3 = 3'($urandom_range(2));
            end else begin
                case ($urandom_range(4))
                    0: f3 = LB;
                    1: f3 = LH;
                    2: f3 = LW;
                    3: f3 = LBU;
                    default: f3 = LHU;
                endcase
            end
            a = ($urandom & 32'hFFFFFC00) | ($urandom_range(15) << 2) | $urandom_range(3);
            ea = ($urandom & 32'hFFFFFF00) | $urandom_range(15);
            cd = $urandom; ed = $urandom; be = 4'($urandom);
            core_req = cr; core_we = cwe; core_addr = a; core_wdata = cd; core_funct3 = f3;
            ext_req = er; ext_we = ewe; ext_addr = ea; ext_wdata = ed; ext_be = be;
            #3;
            exp_cg = cr && (!er || starve != STARVE_MAX);
            exp_eg = er && !exp_cg;
            mis = exp_cg && is_mis(f3, a);
            ci = exp_cg && !mis;
            n = size_of(f3);
            exp_wr = (ci && cwe) || (exp_eg && ewe);
            exp_mask = 4'd0;
            exp_wd = 32'd0;
            if (ci && cwe) begin
                exp_mask = 4'(((1 << n) - 1) << (a % 4));
                exp_wd = (n == 1) ? (cd & 32'hFF) * 32'h01010101 : (n == 2) ? (cd & 32'hFFFF) * 32'h00010001 : cd;
            end else if (exp_eg && ewe) begin
                exp_mask = be;
                exp_wd = ed;
            end
            $display("rand %0d: creq=%0b cwe=%0b a=%h f3=%0d ereq=%0b ewe=%0b ea=%h", t, cr, cwe, a, f3, er, ewe, ea);
            checks++; if (core_gnt !== exp_cg) begin errors++; $display("FAIL rnd_core_gnt[%0d] got %b exp %b", t, core_gnt, exp_cg); end
            checks++; if (ext_gnt !== exp_eg) begin errors++; $display("FAIL rnd_ext_gnt[%0d] got %b exp %b", t, ext_gnt, exp_eg); end
            checks++; if (core_stall !== (cr && !exp_cg)) begin errors++; $display("FAIL rnd_stall[%0d] got %b exp %b", t, core_stall, cr && !exp_cg); end
            checks++; if (core_misalign !== mis) begin errors++; $display("FAIL rnd_misalign[%0d] got %b exp %b", t, core_misalign, mis); end
            checks++; if (mem_cs_E !== !(ci || exp_eg)) begin errors++; $display("FAIL rnd_cs[%0d] got %b exp %b", t, mem_cs_E, !(ci || exp_eg)); end
            checks++; if (mem_wr_E !== exp_wr) begin errors++; $display("FAIL rnd_wr[%0d] got %b exp %b", t, mem_wr_E, exp_wr); end
            checks++; if (mem_mask !== exp_mask) begin errors++; $display("FAIL rnd_mask[%0d] got %b exp %b", t, mem_mask, exp_mask); end
            if (exp_wr) begin
                checks++; if (mem_data_wr !== exp_wd) begin errors++; $display("FAIL rnd_wdata[%0d] got %h exp %h", t, mem_data_wr, exp_wd); end
                checks++; if (mem_addrS !== 32'(ci ? (a >> 2) % DEPTH : ea % DEPTH)) begin errors++; $display("FAIL rnd_addrS[%0d] got %h", t, mem_addrS); end
            end else if (ci || exp_eg) begin
                checks++; if (mem_addrL !== 32'(ci ? (a >> 2) % DEPTH : ea % DEPTH)) begin errors++; $display("FAIL rnd_addrL[%0d] got %h", t, mem_addrL); end
            end
            checks++; if (core_rvalid !== pend_c) begin errors++; $display("FAIL rnd_core_rvalid[%0d] got %b exp %b", t, core_rvalid, pend_c); end
            checks++; if (ext_rvalid !== pend_e) begin errors++; $display("FAIL rnd_ext_rvalid[%0d] got %b exp %b", t, ext_rvalid, pend_e); end
            if (pend_c) begin
                checks++; if (core_rdata !== exp_c) begin errors++; $display("FAIL rnd_core_rdata[%0d] got %h exp %h", t, core_rdata, exp_c); end
            end
            if (pend_e) begin
                checks++; if (ext_rdata !== exp_e) begin errors++; $display("FAIL rnd_ext_rdata[%0d] got %h exp %h", t, ext_rdata, exp_e); end
            end
            if (ci && cwe) ref_store_core(a, f3, cd);
            if (exp_eg && ewe) ref_store_ext(ea, be, ed);
            pend_c = ci && !cwe;
            pend_e = exp_eg && !ewe;
            if (pend_c) exp_c = ref_load(a, f3);
            if (pend_e) exp_e = ref_word(ea);
            if (!er || exp_eg) starve = 0;
            else if (starve < STARVE_MAX) starve++;
            next_cycle();
        end
        idle();
        #3;
        checks++; if (core_rvalid !== pend_c || ext_rvalid !== pend_e) begin errors++; $display("FAIL rnd_tail_rvalid got %b%b exp %b%b", core_rvalid, ext_rvalid, pend_c, pend_e); end
        if (pend_c) begin
            checks++; if (core_rdata !== exp_c) begin errors++; $display("FAIL rnd_tail_core_rdata got %h exp %h", core_rdata, exp_c); end
        end
        if (pend_e) begin
            checks++; if (ext_rdata !== exp_e) begin errors++; $display("FAIL rnd_tail_ext_rdata got %h exp %h", ext_rdata, exp_e); end
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        idle();
        ext_req = 1; ext_we = 0; ext_addr = 32'd8;
        #3;
        $display("reset_mid: ext read issued, reset asserted before posedge");
        checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %b exp 1", ext_gnt); end
        rst_n = 0;
        idle();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #4;
            if (c == 1) rst_n = 1;
            checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_ext_rvalid[%0d] got %b exp 0", c, ext_rvalid); end
            checks++; if (ext_rdata !== 32'd0) begin errors++; $display("FAIL rstmid_ext_rdata[%0d] got %h exp 0", c, ext_rdata); end
            checks++; if (mem_cs_E !== 1'b1 || mem_wr_E !== 1'b0 || mem_mask !== 4'd0) begin errors++; $display("FAIL rstmid_mem[%0d] got cs=%b wr=%b mask=%b", c, mem_cs_E, mem_wr_E, mem_mask); end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_store_load();
        test_sign_ext();
        test_sb();
        test_arbitration();
        test_misalign();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
